// File: rtl/data_mem_be_if.sv
// Bus bundle between the MEM stage and data_mem_be: access request, clear request and read/err response.
interface data_mem_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Handshake: an access is taken on any rising edge where busy is low and
  // rd_en/wr_en is high; there is no ready, so busy is the only back-pressure.
  // rd_valid marks the single cycle in which rd_data/err carry that access's result.
  logic              clr_req;
  logic              busy;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   byte_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              err;

  modport master (
    output clr_req, rd_en, wr_en, addr, wr_data, byte_en,
    input  busy, rd_data, rd_valid, err
  );

  modport slave (
    input  clr_req, rd_en, wr_en, addr, wr_data, byte_en,
    output busy, rd_data, rd_valid, err
  );
endinterface

// File: rtl/data_mem_be.sv
// Byte-enabled, registered-read data memory with a one-word-per-clock clear sweep.
// Optional DATA_MEM_ADDR_CHECK_EN flags misaligned / out-of-range accesses on err.
module data_mem_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_be_if.slave  bus,
  output logic          dbg_clear_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [DATA_W-1:0]  mem_wdata;
  logic [BE_W-1:0]    mem_wbe;

  logic [IDX_W-1:0]   idx;
  logic               acc_bad;
  logic               unused_addr;

  assign idx         = bus.addr[OFF_W+IDX_W-1:OFF_W];
  assign unused_addr = ^bus.addr;

`ifdef DATA_MEM_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);
  assign acc_bad = ((bus.addr & OFF_MASK) != '0) || ((bus.addr >> (OFF_W + IDX_W)) != '0);
`else
  assign acc_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = idx;
    mem_wdata  = bus.wr_data;
    mem_wbe    = bus.byte_en;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          err_d  = (bus.rd_en || bus.wr_en) && acc_bad;
          mem_we = bus.wr_en && !acc_bad;
          // Read samples the array before this edge's write lands: read-first.
          if (bus.rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = acc_bad ? '0 : mem_q[idx];
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset; its contents are defined only by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (mem_wbe[k]) mem_q[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  assign bus.busy     = (state_q == CLEAR);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;
  assign dbg_clear_o  = (state_q == CLEAR);
endmodule

// File: tb/tb_data_mem_be.sv
// Bench for data_mem_be (DATA_W=32, DEPTH=16): vector table, random traffic vs a word-array model,
// and hand sequences for clear sweeps and reset during a sweep / during a read.
module tb_data_mem_be;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 32;
`ifdef DATA_MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_clear;

  data_mem_be_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_be #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_clear_o (dbg_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: plain word array plus the last read value.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] m_rd_data;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          ev;
    logic [31:0] ed;
    bit          ee;
  } vec_t;
  vec_t vecs [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.clr_req = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    bus.byte_en = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_rd_data = '0;
  endtask

  // One accepted IDLE-cycle access, computed from byte-address arithmetic.
  task automatic model_step(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output bit ev, output bit ee);
    bit bad;
    int idx;
    bad = CHK && ((addr % 4) != 0 || addr >= 32'(4 * DEPTH));
    idx = int'((addr / 4) % DEPTH);
    ev  = rd;
    ee  = (rd || wr) && bad;
    if (rd) m_rd_data = bad ? 32'h0 : ref_mem[idx];
    if (wr && !bad)
      for (int k = 0; k < 4; k++)
        if (be[k]) ref_mem[idx][8*k +: 8] = wdata[8*k +: 8];
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.addr    = addr;
    bus.wr_data = wdata;
    bus.byte_en = be;
  endtask

  // Counts edges until busy drops while throwing junk accesses at the memory.
  task automatic wait_sweep(input int exp_edges, input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 63),
            $urandom, 4'hF);
      bus.clr_req = 1'($urandom_range(0, 1));
      tick();
      n++;
      chk({name, "_rd_valid"}, {31'b0, bus.rd_valid}, 32'd0);
    end
    idle_inputs();
    chk({name, "_edges"}, n, exp_edges);
  endtask

  task automatic read_all(input string name);
    bit ev, ee;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4), '0, '0);
      model_step(1'b1, 1'b0, 32'(i * 4), '0, '0, ev, ee);
      tick();
      chk({name, "_valid"}, {31'b0, bus.rd_valid}, {31'b0, ev});
      chk({name, "_data"}, bus.rd_data, m_rd_data);
    end
    idle_inputs();
    tick();
    chk({name, "_valid_drop"}, {31'b0, bus.rd_valid}, 32'd0);
  endtask

  initial begin
    bit ev, ee;
    bit rd, wr;
    logic [31:0] a;

    idle_inputs();
    model_reset();

    // Reset state.
    repeat (3) tick();
    chk("rst_busy", {31'b0, bus.busy}, 32'd1);
    chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'h0);
    rst = 1'b0;
    wait_sweep(DEPTH, "post_reset_sweep");
    read_all("init_read");

    // Vector table; expected values worked out by hand from the access rules.
    vecs.push_back('{1, 0, 32'h8, 32'h0, 4'h0, 1, 32'h0, 0});  // warm read of word 2 before any write
    vecs.push_back('{0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0});
    vecs.push_back('{0, 1, 32'h8, 32'h11223344, 4'h5, 0, 32'h0, 0});
    vecs.push_back('{1, 0, 32'h8, 32'h0, 4'h0, 1, 32'hDE22BE44, 0});
    vecs.push_back('{0, 1, 32'h4, 32'hA5A5A5A5, 4'hF, 0, 32'hDE22BE44, 0});
    vecs.push_back('{1, 1, 32'h4, 32'h12345678, 4'hF, 1, 32'hA5A5A5A5, 0});
    vecs.push_back('{1, 0, 32'h4, 32'h0, 4'h0, 1, 32'h12345678, 0});
    vecs.push_back('{0, 1, 32'h0, 32'hCAFEF00D, 4'h0, 0, 32'h12345678, 0});
    vecs.push_back('{1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0});
    vecs.push_back('{0, 1, 32'h0, 32'h0BADF00D, 4'hF, 0, 32'h0, 0});
    vecs.push_back('{1, 0, 32'h40, 32'h0, 4'h0, 1, CHK ? 32'h0 : 32'h0BADF00D, CHK});
    vecs.push_back('{0, 1, 32'h6, 32'hFFFFFFFF, 4'hF, 0, CHK ? 32'h0 : 32'h0BADF00D, CHK});
    vecs.push_back('{1, 0, 32'h4, 32'h0, 4'h0, 1, CHK ? 32'h12345678 : 32'hFFFFFFFF, 0});
    vecs.push_back('{1, 1, 32'h6, 32'h0, 4'hF, 1, CHK ? 32'h0 : 32'hFFFFFFFF, CHK});
    vecs.push_back('{1, 0, 32'h4, 32'h0, 4'h0, 1, CHK ? 32'h12345678 : 32'h0, 0});
    vecs.push_back('{0, 0, 32'h4, 32'h0, 4'h0, 0, CHK ? 32'h12345678 : 32'h0, 0});
    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      model_step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, ev, ee);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.rd_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d_data", i), bus.rd_data, vecs[i].ed);
      chk($sformatf("vec%0d_err", i), {31'b0, bus.err}, {31'b0, vecs[i].ee});
    end
    idle_inputs();

    // Random traffic against the model; read results flow through an expected queue.
    for (int c = 0; c < 300; c++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) != 0) ? 32'(4 * $urandom_range(0, DEPTH - 1))
                                       : 32'($urandom_range(0, 255));
      drive(rd, wr, a, $urandom, 4'($urandom_range(0, 15)));
      model_step(rd, wr, a, bus.wr_data, bus.byte_en, ev, ee);
      if (ev) exp_q.push_back(m_rd_data);
      tick();
      chk("rand_valid", {31'b0, bus.rd_valid}, {31'b0, ev});
      chk("rand_err", {31'b0, bus.err}, {31'b0, ee});
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("rand_unexpected_valid", 32'd1, 32'd0);
        else chk("rand_data", bus.rd_data, exp_q.pop_front());
      end
      exp_q.delete();
      chk("rand_hold", bus.rd_data, m_rd_data);
    end
    idle_inputs();

    // Clear request wins over a same-cycle write and read.
    drive(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
    bus.clr_req = 1'b1;
    tick();
    idle_inputs();
    chk("clr_busy", {31'b0, bus.busy}, 32'd1);
    chk("clr_dropped_read", {31'b0, bus.rd_valid}, 32'd0);
    wait_sweep(DEPTH, "clr_sweep");
    model_reset();
    m_rd_data = bus.rd_data;
    read_all("after_clr");

    // Reset at sweep count 7 restarts the full sweep.
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #2;
    chk("midsweep_rst_busy", {31'b0, bus.busy}, 32'd1);
    tick();
    tick();
    chk("midsweep_rst_busy_held", {31'b0, bus.busy}, 32'd1);
    rst = 1'b0;
    wait_sweep(DEPTH, "midsweep_restart");

    // Reset landing on an in-flight read: no rd_valid, full sweep follows.
    drive(1'b1, 1'b0, 32'h8, '0, '0);
    #3;
    rst = 1'b1;
    tick();
    chk("inflight_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("inflight_rd_data", bus.rd_data, 32'h0);
    idle_inputs();
    rst = 1'b0;
    wait_sweep(DEPTH, "inflight_sweep");
    model_reset();
    read_all("final_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/data_mem_be.md
Name: data_mem_be

Overview:
- Parametrised, byte-enabled, synchronous-read data memory for the datapath's MEM stage. Successor to the single-width flat data memory.
- Adds configurable data width and depth, per-byte write enables, a registered read port with a valid strobe, and a multi-cycle clear engine in place of a single-cycle array wipe.
- A clear sweep runs automatically after reset and can also be requested at runtime; `busy` stalls the pipeline while a sweep is active.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; must be a power of 2 and ≥ 2.
- ADDR_W, 32, byte-address width.
- Derived constants (not overridable):
  - BE_W = DATA_W/8
  - OFF_W = log2(BE_W)
  - IDX_W = log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr_req  in  1  start a clear sweep (sampled only in IDLE)
- busy  out  1  clear sweep in progress; accesses are ignored while high
- rd_en  in  1  read request
- wr_en  in  1  write request
- addr  in  ADDR_W  byte address, shared by read and write
- wr_data  in  DATA_W  write data
- byte_en  in  BE_W  per-byte write enables; bit k covers wr_data[8k+7:8k]
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: rd_data updated this cycle
- err  out  1  one-cycle access-error strobe (see Optional Feature)

Behaviour:
- Reset is decided as: asynchronous, active-high `rst`; clock `clk`.
- Reset values:
  - rd_data = 0, rd_valid = 0, err = 0.
  - busy = 1, state = CLEAR, sweep counter = 0.
- Address decode: idx = addr[OFF_W+IDX_W-1 : OFF_W]. Without the optional feature, addr[OFF_W-1:0] and bits above the index are ignored, so addresses wrap modulo DEPTH words.
- States:
  - IDLE: accepts accesses.
  - CLEAR: writes zero to one word per clock.
- CLEAR operation, per rising edge:
  - mem[cnt] <= 0.
  - If cnt == DEPTH-1: go to IDLE and set busy <= 0. Otherwise cnt <= cnt+1.
  - A sweep takes exactly DEPTH edges. After reset release, busy falls on the DEPTH-th edge.
- IDLE transitions and priority:
  - If clr_req == 1: go to CLEAR, cnt <= 0, busy <= 1. clr_req has priority; any rd_en/wr_en in that same cycle is dropped (no write, no rd_valid).
  - Otherwise, service rd_en and/or wr_en.
- Write:
  - On the edge with wr_en = 1, for each k with byte_en[k] = 1: mem[idx][8k+7:8k] <= wr_data[8k+7:8k]. Bytes with byte_en[k] = 0 are unchanged.
  - byte_en = 0 makes the write a no-op.
- Read:
  - On the edge with rd_en = 1, rd_data <= mem[idx] and rd_valid <= 1. Read latency is 1 cycle.
  - rd_valid is 0 on every other edge. rd_data holds its last value when not reading.
- Simultaneous read and write to the same idx: read-first; rd_data returns the pre-write word. The written value is visible to a read on the next cycle.
- During CLEAR:
  - rd_en, wr_en and clr_req are ignored; rd_valid = 0.
  - Words not yet swept keep their old contents but cannot be accessed.
- Reset asserted mid-sweep or mid-access aborts it immediately and restarts the sweep at cnt = 0. The in-flight read produces no rd_valid.
- Back-to-back reads: a read every cycle yields rd_valid continuously high with a new rd_data each cycle.

Optional Feature:
- Macro: DATA_MEM_ADDR_CHECK_EN.
- When defined:
  - An access accepted in IDLE is erroneous if addr[OFF_W-1:0] != 0 (misaligned) or any addr bit above OFF_W+IDX_W-1 is set (out of range).
  - On an erroneous access, err <= 1 for one cycle, registered alongside rd_valid.
  - An erroneous write is suppressed; the memory is unchanged.
  - An erroneous read sets rd_data <= 0 with rd_valid <= 1.
  - One err pulse is produced per cycle even if rd_en and wr_en are both high.
- When undefined: err is constant 0 and addresses wrap as described in Behaviour.

Test Plan:
- Bench configuration: DATA_W = 32, DEPTH = 16.
- Reset release → busy is high for exactly 16 edges, then 0. Reads of all 16 words return 0x00000000 with rd_valid one cycle after each rd_en.
- Write 0xDEADBEEF, byte_en = 4'hF at addr 0x8; then write 0x11223344, byte_en = 4'b0101 at 0x8; read 0x8 → rd_data = 0xDE22BE44.
- Same-cycle rd_en + wr_en at addr 0x4 (old value 0xA5A5A5A5, new 0x12345678) → rd_data = 0xA5A5A5A5. Next-cycle read → 0x12345678.
- clr_req pulse with wr_en high in the same cycle:
  - busy = 1 for 16 edges.
  - The write is dropped.
  - rd_en pulses during busy produce no rd_valid.
  - All words read 0 afterwards.
- Assert rst at sweep count 7 → busy stays 1, and the sweep completes 16 edges after rst release.
- With DATA_MEM_ADDR_CHECK_EN defined:
  - Write at addr 0x6 → err pulses one cycle and the memory is unchanged.
  - Read at addr 0x40 → err = 1, rd_valid = 1, rd_data = 0.
- Without the macro: read at addr 0x40 returns mem[0].
